// File: rtl/cmp_pkg.sv
// Shared types and defaults for the streaming equality checker.
package cmp_pkg;
   localparam int CMP_WIDTH = 32;
   localparam int CMP_LEN_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } cmp_state_t;
endpackage

// File: rtl/eq32_cmp.sv
// Combinational WIDTH-bit equality comparator.
module eq32_cmp #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             eq
);
   assign eq = (a == b);
endmodule

// File: rtl/cmp_stream_checker.sv
// Streaming equality checker: registers operand pairs into the
// comparator and accumulates match/mismatch statistics per run.
module cmp_stream_checker
   import cmp_pkg::*;
#(
   parameter int WIDTH = CMP_WIDTH,
   parameter int LEN_W = CMP_LEN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             busy,
   output logic             done,
   output logic             all_eq,
   output logic [LEN_W-1:0] match_cnt,
   output logic [LEN_W-1:0] mismatch_cnt,
   output logic [LEN_W-1:0] first_mm_idx,
   output logic             first_mm_valid
);
   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   cmp_state_t       state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] acc_q, acc_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             v_q, v_d;
   logic [LEN_W-1:0] match_q, match_d;
   logic [LEN_W-1:0] mism_q, mism_d;
   logic [LEN_W-1:0] fidx_q, fidx_d;
   logic             fv_q, fv_d;
   logic             aeq_q, aeq_d;
   logic             eq;
   logic             hs;
   logic             accept;
   logic [LEN_W-1:0] acc_nxt;

   eq32_cmp #(.WIDTH(WIDTH)) u_eq (
      .a  (a_q),
      .b  (b_q),
      .eq (eq)
   );

   assign hs      = in_valid && in_ready;
   assign accept  = (state_q == IDLE) && start;
   assign acc_nxt = acc_q + LEN_ONE;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = (len == '0) ? DONE : RUN;
         end
         RUN: begin
            if (hs && (acc_nxt == len_q)) state_d = FLUSH;
         end
         FLUSH:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // all_eq is live during DONE so it is valid together with the pulse.
   always_comb begin
      in_ready       = (state_q == RUN) && (acc_q < len_q);
      busy           = (state_q != IDLE);
      done           = (state_q == DONE);
      all_eq         = (state_q == DONE) ? (mism_q == '0) : aeq_q;
      match_cnt      = match_q;
      mismatch_cnt   = mism_q;
      first_mm_idx   = fidx_q;
      first_mm_valid = fv_q;
   end

   always_comb begin
      len_d   = len_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      v_d     = hs;
      match_d = match_q;
      mism_d  = mism_q;
      fidx_d  = fidx_q;
      fv_d    = fv_q;
      aeq_d   = aeq_q;
      if (hs) begin
         a_d   = in_a;
         b_d   = in_b;
         idx_d = acc_q;
         acc_d = acc_nxt;
      end
      if (accept) begin
         len_d   = len;
         acc_d   = '0;
         match_d = '0;
         mism_d  = '0;
         fidx_d  = '0;
         fv_d    = 1'b0;
         aeq_d   = (len == '0);
      end else if (v_q) begin
         if (eq) begin
            match_d = match_q + LEN_ONE;
         end else begin
            mism_d = mism_q + LEN_ONE;
            if (!fv_q) begin
               fidx_d = idx_q;
               fv_d   = 1'b1;
            end
         end
      end
      if (state_q == DONE) aeq_d = (mism_q == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_q   <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         v_q     <= 1'b0;
         match_q <= '0;
         mism_q  <= '0;
         fidx_q  <= '0;
         fv_q    <= 1'b0;
         aeq_q   <= 1'b0;
      end else begin
         len_q   <= len_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         v_q     <= v_d;
         match_q <= match_d;
         mism_q  <= mism_d;
         fidx_q  <= fidx_d;
         fv_q    <= fv_d;
         aeq_q   <= aeq_d;
      end
   end
endmodule
